// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I decode + execute stage with valid/ready handshakes on both sides.
//
// Decodes {opcode, func7, func3} into an ALU control code, computes the result and registers
// it. Non-shift ops complete in one cycle; shifts with a non-zero shift amount are run on an
// iterative shifter that moves SHIFT_PER_CYCLE bit positions per cycle.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   in_valid       operation and operands valid
//   in_ready       unit accepts the operation this cycle
//   opcode/func3/func7  instruction fields to decode
//   op_a, op_b     operands (shamt = op_b[$clog2(XLEN)-1:0])
//   out_valid      result/zero/illegal/alu_control valid
//   out_ready      consumer takes the result this cycle
//   result         registered result
//   zero           result == 0
//   illegal        operation did not decode (result forced to 0)
//   alu_control    decoded control code of the op being output
module alu_exec_unit #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned SHIFT_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic [3:0]      alu_control
);

    localparam int unsigned SHW = $clog2(XLEN);
    // One extra bit so the step size can be compared/held even when SHIFT_PER_CYCLE == XLEN.
    localparam int unsigned CW  = SHW + 1;
    localparam logic [CW-1:0] StepMax = CW'(SHIFT_PER_CYCLE);

    localparam logic [3:0] AluAnd     = 4'b0000;
    localparam logic [3:0] AluOr      = 4'b0001;
    localparam logic [3:0] AluAdd     = 4'b0010;
    localparam logic [3:0] AluXor     = 4'b0011;
    localparam logic [3:0] AluSll     = 4'b0100;
    localparam logic [3:0] AluSrl     = 4'b0101;
    localparam logic [3:0] AluSub     = 4'b0110;
    localparam logic [3:0] AluSra     = 4'b0111;
    localparam logic [3:0] AluSlt     = 4'b1000;
    localparam logic [3:0] AluSltu    = 4'b1001;
    localparam logic [3:0] AluPassB   = 4'b1010;
    localparam logic [3:0] AluIllegal = 4'b1111;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;   // doubles as the shift register while in StShift
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [SHW-1:0]  rem_q, rem_d;

    logic [3:0]      dec_ctrl;
    logic            dec_is_shift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            accept;
    logic [CW-1:0]   rem_ext, step, rem_next;
    logic [XLEN-1:0] shifted;

    // ---------------------------------------------------------------- decode
    always_comb begin
        dec_ctrl = AluIllegal;
        case (opcode)
            OpLoad, OpStore: dec_ctrl = AluAdd;
            OpLui:           dec_ctrl = AluPassB;
            OpBranch: begin
                case (func3)
                    3'b000, 3'b001: dec_ctrl = AluSub;
                    3'b100, 3'b101: dec_ctrl = AluSlt;
                    3'b110, 3'b111: dec_ctrl = AluSltu;
                    default:        dec_ctrl = AluIllegal;
                endcase
            end
            OpReg: begin
                if (func7 == F7Base) begin
                    case (func3)
                        3'b000:  dec_ctrl = AluAdd;
                        3'b001:  dec_ctrl = AluSll;
                        3'b010:  dec_ctrl = AluSlt;
                        3'b011:  dec_ctrl = AluSltu;
                        3'b100:  dec_ctrl = AluXor;
                        3'b101:  dec_ctrl = AluSrl;
                        3'b110:  dec_ctrl = AluOr;
                        default: dec_ctrl = AluAnd;
                    endcase
                end else if (func7 == F7Alt) begin
                    if (func3 == 3'b000) begin
                        dec_ctrl = AluSub;
                    end else if (func3 == 3'b101) begin
                        dec_ctrl = AluSra;
                    end
                end
            end
            OpImm: begin
                case (func3)
                    3'b000: dec_ctrl = AluAdd;
                    3'b010: dec_ctrl = AluSlt;
                    3'b011: dec_ctrl = AluSltu;
                    3'b100: dec_ctrl = AluXor;
                    3'b110: dec_ctrl = AluOr;
                    3'b111: dec_ctrl = AluAnd;
                    3'b001: dec_ctrl = (func7 == F7Base) ? AluSll : AluIllegal;
                    default: begin
                        if (func7 == F7Base) begin
                            dec_ctrl = AluSrl;
                        end else if (func7 == F7Alt) begin
                            dec_ctrl = AluSra;
                        end
                    end
                endcase
            end
            default: dec_ctrl = AluIllegal;
        endcase
    end

    assign dec_is_shift = (dec_ctrl == AluSll) || (dec_ctrl == AluSrl) || (dec_ctrl == AluSra);
    assign shamt        = op_b[SHW-1:0];

    // ------------------------------------------------------- single-cycle ALU
    // Shifts only reach this path with shamt == 0, where the result is op_a unchanged.
    always_comb begin
        alu_res = '0;
        case (dec_ctrl)
            AluAnd:   alu_res = op_a & op_b;
            AluOr:    alu_res = op_a | op_b;
            AluAdd:   alu_res = op_a + op_b;
            AluXor:   alu_res = op_a ^ op_b;
            AluSub:   alu_res = op_a - op_b;
            AluSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            AluSltu:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            AluPassB: alu_res = op_b;
            AluSll, AluSrl, AluSra: alu_res = op_a;
            default:  alu_res = '0;
        endcase
    end

    // ------------------------------------------------------ iterative shifter
    always_comb begin
        rem_ext  = {1'b0, rem_q};
        step     = (rem_ext >= StepMax) ? StepMax : rem_ext;
        rem_next = rem_ext - step;
        case (ctrl_q)
            AluSll:  shifted = result_q << step;
            AluSra:  shifted = $signed(result_q) >>> step;
            default: shifted = result_q >> step;
        endcase
    end

    // ------------------------------------------------------------- handshake
    // HOLD with out_ready frees the output register this cycle, so a new op may enter.
    assign in_ready  = !rst && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
    assign out_valid = !rst && (state_q == StHold);
    assign accept    = in_valid && in_ready;

    // ------------------------------------------------------- next-state logic
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        ctrl_d    = ctrl_q;
        rem_d     = rem_q;

        case (state_q)
            StIdle, StHold: begin
                if ((state_q == StHold) && out_ready) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    ctrl_d    = dec_ctrl;
                    illegal_d = (dec_ctrl == AluIllegal);
                    if (dec_is_shift && (shamt != '0)) begin
                        state_d  = StShift;
                        result_d = op_a;
                        rem_d    = shamt;
                    end else begin
                        state_d  = StHold;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                    end
                end
            end
            StShift: begin
                result_d = shifted;
                rem_d    = rem_next[SHW-1:0];
                if (rem_next == '0) begin
                    state_d = StHold;
                    zero_d  = (shifted == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= AluAnd;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
            rem_q     <= rem_d;
        end
    end

    assign result      = result_q;
    assign zero        = zero_q;
    assign illegal     = illegal_q;
    assign alu_control = ctrl_q;

endmodule
